// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state type and default slot timing for sdram_slot_arbiter.
package sdram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Default slot length (clk cycles) and read-capture phase within the slot.
  localparam int ARB_SLOT_CYCLES = 8;
  localparam int ARB_RD_CAPTURE  = 7;

endpackage

// File: rtl/sdram_slot_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority finder. Searches last_i+1, last_i+2, ...
// modulo NREQ and returns the first requester found plus a valid flag.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [IW-1:0]   gnt_o,
  output logic            vld_o
);

  // Doubling the vector lets a single right shift rotate the search origin to bit 0.
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;

  assign dbl   = {req_i, req_i} >> (int'(last_i) + 1);
  assign rot   = dbl[NREQ-1:0];
  assign vld_o = |req_i;

  // Lowest set bit of the rotated vector is the nearest requester after last_i.
  always_comb begin
    gnt_o = '0;
    for (int p = NREQ - 1; p >= 0; p--) begin
      if (rot[p]) gnt_o = IW'((int'(last_i) + 1 + p) % NREQ);
    end
  end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// sdram_slot_arbiter: shares one sdram controller port between NREQ requesters.
// One access per SLOT_CYCLES-long slot, granted at phase 0, acked at the slot end.
// Optional build macro SDRAM_ARB_PRIO0_EN: requester 0 gets fixed top priority and
// the remaining requesters rotate among themselves.
module sdram_slot_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int AW          = 25,
  parameter int DW          = 8,
  parameter int SLOT_CYCLES = ARB_SLOT_CYCLES,
  parameter int RD_CAPTURE  = ARB_RD_CAPTURE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_din,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rdata,
  output logic              clkref,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_din,
  input  logic [DW-1:0]     mem_dout
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(SLOT_CYCLES);
  localparam logic [PW-1:0] PH_LAST = PW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] PH_CAP  = PW'(RD_CAPTURE);
  localparam logic [PW-1:0] PH_HALF = PW'(SLOT_CYCLES / 2);

  logic [PW-1:0]   phase_q, phase_d;
  logic            clkref_q;
  arb_state_e      state_q;
  logic [IW-1:0]   last_q, g_q;
  logic            oe_q, we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   din_q, rdata_q;
  logic [NREQ-1:0] ack_q, ack_d;

  logic [NREQ-1:0] rr_req;
  logic [IW-1:0]   rr_g, pick_g;
  logic            rr_v, pick_v, upd_last;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_din;
  logic            sel_we;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i  (rr_req),
    .last_i (last_q),
    .gnt_o  (rr_g),
    .vld_o  (rr_v)
  );

`ifdef SDRAM_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation; only grants to others move last_grant.
  assign rr_req   = {req[NREQ-1:1], 1'b0};
  assign pick_v   = req[0] | rr_v;
  assign pick_g   = req[0] ? '0 : rr_g;
  assign upd_last = ~req[0] & rr_v;
`else
  assign rr_req   = req;
  assign pick_v   = rr_v;
  assign pick_g   = rr_g;
  assign upd_last = rr_v;
`endif

  assign phase_d = phase_q + PW'(1);

  // Select the winning requester's fields for latching at slot start.
  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_we   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_g == IW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_din  = req_din[i*DW +: DW];
        sel_we   = req_we[i];
      end
    end
  end

  // Completion pulse for the slot owner on the last phase of a busy slot.
  always_comb begin
    ack_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack_d[i] = (state_q == BUSY) && (phase_q == PH_LAST) && (g_q == IW'(i));
    end
  end

  // Free-running slot phase and the clkref strobe aligned to it.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= '0;
      clkref_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      clkref_q <= (phase_d >= PH_HALF);
    end
  end

  // Slot ownership: decide at phase 0, hold the controller outputs for the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IW'(NREQ - 1);
      g_q     <= '0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else if (phase_q == '0) begin
      if (pick_v) begin
        state_q <= BUSY;
        g_q     <= pick_g;
        oe_q    <= ~sel_we;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        din_q   <= sel_din;
        if (upd_last) last_q <= pick_g;
      end else begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
        we_q    <= 1'b0;
      end
    end
  end

  // Read data capture and one-cycle ack; rdata holds between captures.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      ack_q   <= '0;
    end else begin
      ack_q <= ack_d;
      if ((state_q == BUSY) && (phase_q == PH_CAP) && !we_q) rdata_q <= mem_dout;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign clkref   = clkref_q;
  assign mem_oe   = oe_q;
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// tb_sdram_slot_arbiter: directed scenarios plus random requesters, all checked
// every cycle against a slot-level reference model and a simple SDRAM model.
module tb_sdram_slot_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 25;
  localparam int DW   = 8;
  localparam int SLOT = 8;
  localparam int RDC  = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0]    req = '0, req_we = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_din = '0;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               clkref, mem_oe, mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_din;
  logic [DW-1:0]      mem_dout = 8'hEE;

  sdram_slot_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SLOT_CYCLES(SLOT), .RD_CAPTURE(RDC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_din(req_din), .ack(ack), .rdata(rdata), .clkref(clkref), .mem_oe(mem_oe),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  logic [DW-1:0] sdram [int];
  logic [DW-1:0] ref_mem [int];

  // Reference model state: phase of the current cycle, slot owner (-1 = none).
  int            m_ph, m_own, m_last;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [NREQ-1:0] e_ack;
  logic [DW-1:0] e_rdata;
  bit            e_oe, e_mwe, e_clkref;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [DW-1:0] sd_rd(input logic [AW-1:0] a);
    return sdram.exists(int'(a)) ? sdram[int'(a)] : fill(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : fill(a);
  endfunction

  // Nearest requester after m_last, modulo NREQ; -1 when nobody asks.
  function automatic int model_pick();
    int g = -1;
`ifdef SDRAM_ARB_PRIO0_EN
    if (req[0]) return 0;
    for (int k = 1; k <= NREQ; k++) begin
      int i = (m_last + k) % NREQ;
      if (i != 0 && req[i] && g < 0) g = i;
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      int i = (m_last + k) % NREQ;
      if (req[i] && g < 0) g = i;
    end
`endif
    return g;
  endfunction

  task automatic model_edge();
    int g;
    if (reset) begin
      m_ph = 0; m_own = -1; m_last = NREQ - 1; m_we = 0; m_addr = '0; m_din = '0;
      e_ack = '0; e_rdata = '0; e_oe = 0; e_mwe = 0; e_clkref = 0;
      return;
    end
    e_ack = '0;
    if (m_own >= 0 && m_ph == SLOT - 1) begin
      e_ack = NREQ'(1) << m_own;
      if (m_we) ref_mem[int'(m_addr)] = m_din;
    end
    if (m_own >= 0 && m_ph == RDC && !m_we) e_rdata = ref_rd(m_addr);
    if (m_ph == 0) begin
      g = model_pick();
      m_own = g;
      if (g >= 0) begin
        m_we   = req_we[g];
        m_addr = req_addr[g*AW +: AW];
        m_din  = req_din[g*DW +: DW];
        e_oe   = !m_we;
        e_mwe  = m_we;
        if (g != 0 || model_is_rr()) m_last = g;
      end else begin
        e_oe = 0; e_mwe = 0;
      end
    end
    m_ph = (m_ph + 1) % SLOT;
    e_clkref = (m_ph >= SLOT / 2);
  endtask

  function automatic bit model_is_rr();
`ifdef SDRAM_ARB_PRIO0_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  // One clock: advance model, compare every output, then play the SDRAM side.
  task automatic tick();
    @(posedge clk); #1;
    model_edge();
    chk("ack", 32'(ack), 32'(e_ack));
    chk("clkref", 32'(clkref), 32'(e_clkref));
    chk("mem_oe", 32'(mem_oe), 32'(e_oe));
    chk("mem_we", 32'(mem_we), 32'(e_mwe));
    chk("rdata", 32'(rdata), 32'(e_rdata));
    if (e_oe || e_mwe) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (e_mwe) chk("mem_din", 32'(mem_din), 32'(m_din));
    if (mem_we && m_ph == SLOT - 1) sdram[int'(mem_addr)] = mem_din;
    mem_dout = (mem_oe && m_ph == RDC) ? sd_rd(mem_addr) : 8'hEE;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    req = '0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_din[i*DW +: DW] = d;
  endtask

  task automatic wait_ack(input int i, output int n);
    bit seen = 0;
    n = 0;
    while (!seen && n < 64) begin
      tick(); n++; seen = ack[i];
    end
    chk("ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_any(output int idx, output int n);
    bit seen = 0;
    n = 0; idx = -1;
    while (!seen && n < 64) begin
      tick(); n++;
      for (int b = NREQ - 1; b >= 0; b--) if (ack[b]) begin seen = 1; idx = b; end
    end
    chk("any_ack_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int n, idx, tog, anyack, guard;
    bit prev;
    bit [NREQ-1:0] pend;

    // Reset, then 32 idle cycles
    do_reset(3);
    chk("rst_clkref", 32'(clkref), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    tog = 0; anyack = 0; prev = clkref;
    repeat (32) begin
      tick();
      if (clkref != prev) tog++;
      prev = clkref;
      anyack |= int'(|ack) | int'(mem_oe) | int'(mem_we);
    end
    chk("idle_clkref_toggles", 32'(tog), 32'd8);
    chk("idle_activity", 32'(anyack), 32'd0);

    // Requester 1 write then read-back at the same address
    set_req(1, 1'b1, 25'h00012, 8'hA5);
    wait_ack(1, n);
    req_we[1] = 1'b0;
    wait_ack(1, n);
    chk("readback_a5", 32'(rdata), 32'hA5);
    chk("readback_gap", 32'(n), 32'(SLOT));
    req = '0;

    // All four requesting continuously: strict rotation, one slot apart
    do_reset(2);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(32'h100 + i), 8'h00);
    for (int k = 0; k < 2 * NREQ; k++) begin
      wait_any(idx, n);
      chk("rr_order", 32'(idx), 32'(k % NREQ));
      if (k > 0) chk("rr_spacing", 32'(n), 32'(SLOT));
    end
    req = '0;

    // Request raised mid-slot waits for the next phase 0
    guard = 0;
    while (!(m_ph == 3 && m_own < 0) && guard < 64) begin tick(); guard++; end
    set_req(2, 1'b0, 25'h00020, 8'h00);
    wait_ack(2, n);
    chk("mid_slot_latency", 32'(n), 32'((SLOT - 3) + SLOT));
    req = '0;

    // Reset in the middle of a busy read slot
    set_req(1, 1'b0, 25'h00033, 8'h00);
    guard = 0;
    while (!(m_own == 1 && m_ph == 4) && guard < 64) begin tick(); guard++; end
    reset = 1'b1;
    tick();
    chk("rst_mid_oe", 32'(mem_oe), 32'd0);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    tick();
    reset = 1'b0;
    set_req(0, 1'b0, 25'h00040, 8'h00);
    set_req(3, 1'b0, 25'h00043, 8'h00);
    wait_any(idx, n);
    chk("post_rst_first", 32'(idx), 32'd0);
    req = '0;

`ifdef SDRAM_ARB_PRIO0_EN
    // Requester 0 starves requester 3 until it lets go
    do_reset(2);
    set_req(0, 1'b0, 25'h00050, 8'h00);
    set_req(3, 1'b0, 25'h00053, 8'h00);
    for (int k = 0; k < 4; k++) begin
      wait_any(idx, n);
      chk("prio0_only", 32'(idx), 32'd0);
    end
    req[0] = 1'b0;
    wait_any(idx, n);
    chk("prio_then_3", 32'(idx), 32'd3);
    chk("prio_then_3_gap", 32'(n), 32'(SLOT));
    req = '0;
`endif

    // Random requesters honouring the hold-until-ack contract
    pend = '0;
    repeat (800) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) pend[i] = 1'b0;
        if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            pend[i] = 1'b1;
          end else begin
            req[i] = 1'b0;
          end
        end
      end
    end
    req = '0;
    repeat (2 * SLOT) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
